// File: rtl/spram_rr_arbiter.sv
// Two-requester round-robin front end for one single-port RAM, with a read tag
// pipeline that routes responses home. Optional error log: SPRAM_ARB_PERR_LOG_EN.
`timescale 1ns/1ps
module spram_rr_arbiter #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 2,
  parameter int BYTE_WRITE_EN = 0,
  localparam int WE_W = (BYTE_WRITE_EN != 0) ? DATA_WIDTH / 8 : 1
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic [WE_W-1:0]       m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  output logic                  m0_rsp_perr,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic [WE_W-1:0]       m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  m1_rsp_perr,
  output logic                  ram_rsta,
  output logic                  ram_ena,
  output logic [WE_W-1:0]       ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  input  logic [DATA_WIDTH-1:0] ram_douta,
  input  logic                  ram_parity_err,
  input  logic                  perr_clr,
  output logic                  perr_sticky,
  output logic [ADDR_WIDTH-1:0] perr_addr,
  output logic [7:0]            perr_cnt
);

  typedef struct packed {
    logic v;
    logic id;
`ifdef SPRAM_ARB_PERR_LOG_EN
    logic [ADDR_WIDTH-1:0] addr;
`endif
  } tag_t;

  logic                  last_grant_q, last_grant_d;
  logic                  ena_q, ena_d;
  logic [WE_W-1:0]       wea_q, wea_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dina_q, dina_d;
  logic                  cmd_id_q, cmd_id_d;
  logic                  perr_sticky_q, perr_sticky_d;
  logic                  gnt0, gnt1;
  logic                  rd_launch, rsp_fire, rsp_id, err_evt;
  tag_t                  head_tag;
  tag_t                  tag_q [READ_LATENCY];
  tag_t                  tag_d [READ_LATENCY];

  // last_grant_q holds the id of the most recent winner; the other side wins a tie.
  always_comb begin
    gnt0 = m0_valid && (!m1_valid || last_grant_q);
    gnt1 = m1_valid && !gnt0;
  end

  assign m0_ready = rsta_n && gnt0;
  assign m1_ready = rsta_n && gnt1;

  always_comb begin
    ena_d        = 1'b0;
    wea_d        = '0;
    addr_d       = addr_q;
    dina_d       = dina_q;
    cmd_id_d     = cmd_id_q;
    last_grant_d = last_grant_q;
    if (m0_ready) begin
      ena_d        = 1'b1;
      wea_d        = m0_we;
      addr_d       = m0_addr;
      dina_d       = m0_wdata;
      cmd_id_d     = 1'b0;
      last_grant_d = 1'b0;
    end else if (m1_ready) begin
      ena_d        = 1'b1;
      wea_d        = m1_we;
      addr_d       = m1_addr;
      dina_d       = m1_wdata;
      cmd_id_d     = 1'b1;
      last_grant_d = 1'b1;
    end
  end

  assign ram_rsta  = ~rsta_n;
  assign ram_ena   = ena_q;
  assign ram_wea   = wea_q;
  assign ram_addra = addr_q;
  assign ram_dina  = dina_q;

  assign rd_launch = ena_q && (wea_q == '0);

  always_comb begin
    head_tag    = '0;
    head_tag.v  = rd_launch;
    head_tag.id = cmd_id_q;
`ifdef SPRAM_ARB_PERR_LOG_EN
    head_tag.addr = addr_q;
`endif
  end

  // One tag stage per cycle of RAM read latency, so the tail lines up with ram_douta.
  for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      assign tag_d[gi] = head_tag;
    end else begin : g_body
      assign tag_d[gi] = tag_q[gi-1];
    end
    always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) tag_q[gi] <= '0;
      else         tag_q[gi] <= tag_d[gi];
    end
  end

  assign rsp_fire = tag_q[READ_LATENCY-1].v;
  assign rsp_id   = tag_q[READ_LATENCY-1].id;
  assign err_evt  = rsp_fire && ram_parity_err;

  assign m0_rsp_valid = rsp_fire && !rsp_id;
  assign m1_rsp_valid = rsp_fire && rsp_id;
  assign m0_rsp_rdata = ram_douta;
  assign m1_rsp_rdata = ram_douta;
  assign m0_rsp_perr  = m0_rsp_valid && ram_parity_err;
  assign m1_rsp_perr  = m1_rsp_valid && ram_parity_err;

  assign perr_sticky_d = err_evt || (perr_sticky_q && !perr_clr);
  assign perr_sticky   = perr_sticky_q;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      last_grant_q  <= 1'b1;
      ena_q         <= 1'b0;
      wea_q         <= '0;
      addr_q        <= '0;
      dina_q        <= '0;
      cmd_id_q      <= 1'b0;
      perr_sticky_q <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      ena_q         <= ena_d;
      wea_q         <= wea_d;
      addr_q        <= addr_d;
      dina_q        <= dina_d;
      cmd_id_q      <= cmd_id_d;
      perr_sticky_q <= perr_sticky_d;
    end
  end

`ifdef SPRAM_ARB_PERR_LOG_EN
  logic [ADDR_WIDTH-1:0] perr_addr_q, perr_addr_d;
  logic [7:0]            perr_cnt_q, perr_cnt_d;

  // A clear re-arms address capture, so an error in the clearing cycle is logged.
  always_comb begin
    perr_addr_d = perr_addr_q;
    perr_cnt_d  = perr_cnt_q;
    if (err_evt && (!perr_sticky_q || perr_clr))
      perr_addr_d = tag_q[READ_LATENCY-1].addr;
    if (perr_clr)
      perr_cnt_d = err_evt ? 8'd1 : 8'd0;
    else if (err_evt && (perr_cnt_q != 8'hFF))
      perr_cnt_d = perr_cnt_q + 8'd1;
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      perr_addr_q <= '0;
      perr_cnt_q  <= '0;
    end else begin
      perr_addr_q <= perr_addr_d;
      perr_cnt_q  <= perr_cnt_d;
    end
  end

  assign perr_addr = perr_addr_q;
  assign perr_cnt  = perr_cnt_q;
`else
  assign perr_addr = '0;
  assign perr_cnt  = '0;
`endif

endmodule
